rf_writeback_queue: RTL

- Producer-side counterpart of the 4-entry, 16-bit register file.
- Collects writeback requests from two producers, the ALU and MEM stages, and buffers them in a small in-order FIFO.
- Drains the FIFO one write per cycle onto the register file's single write port (rd / w_data / RegWrite).
- Forwards the youngest pending value for the two read addresses, so readers never see a stale register value while writes are queued.

---
 rtl/rf_writeback_queue.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: in-order ALU/MEM writeback FIFO drained one write/cycle onto the RF port, accept-to-RegWrite >= 1 cycle;
// ready drops on occupancy at cycle start (no same-cycle pop credit), youngest-wins read forwarding. Option: RF_WBQ_STALL_CNT_EN.
module rf_writeback_queue #(
   parameter int WORD_SIZE = 16,
   parameter int DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   alu_valid,
   input  logic [1:0]             alu_rd,
   input  logic [WORD_SIZE-1:0]   alu_data,
   output logic                   alu_ready,
   input  logic                   mem_valid,
   input  logic [1:0]             mem_rd,
   input  logic [WORD_SIZE-1:0]   mem_data,
   output logic                   mem_ready,
   output logic [1:0]             rd,
   output logic [WORD_SIZE-1:0]   w_data,
   output logic                   RegWrite,
   input  logic [1:0]             rs,
   input  logic [1:0]             rt,
   input  logic [WORD_SIZE-1:0]   r_data1,
   input  logic [WORD_SIZE-1:0]   r_data2,
   output logic [WORD_SIZE-1:0]   fwd_data1,
   output logic [WORD_SIZE-1:0]   fwd_data2,
   output logic [$clog2(DEPTH):0] pending
`ifdef RF_WBQ_STALL_CNT_EN
   ,
   output logic [15:0]            stall_cnt
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [1:0]           r_q_rd  [DEPTH];
   logic [WORD_SIZE-1:0] r_q_dat [DEPTH];
   logic [PW-1:0]        r_wptr;
   logic [PW-1:0]        r_rptr;
   logic [CW-1:0]        r_count;

   logic                 w_mem_push;
   logic                 w_alu_push;
   logic                 w_pop;
   logic [1:0]           w_npush;
   logic [PW-1:0]        w_alu_slot;
   logic [WORD_SIZE-1:0] w_fwd1;
   logic [WORD_SIZE-1:0] w_fwd2;

   assign mem_ready  = (r_count < CW'(DEPTH));
   assign alu_ready  = ((r_count + CW'(mem_valid)) < CW'(DEPTH));
   assign w_mem_push = mem_valid & mem_ready;
   assign w_alu_push = alu_valid & alu_ready;
   assign w_pop      = (r_count != '0);
   assign w_npush    = {1'b0, w_mem_push} + {1'b0, w_alu_push};
   // MEM takes the first free slot so ALU is always the younger of a pair
   assign w_alu_slot = r_wptr + PW'(w_mem_push);
   assign pending    = r_count;

   always_ff @(posedge clk) begin
      if (w_mem_push) begin
         r_q_rd[r_wptr]  <= mem_rd;
         r_q_dat[r_wptr] <= mem_data;
      end
      if (w_alu_push) begin
         r_q_rd[w_alu_slot]  <= alu_rd;
         r_q_dat[w_alu_slot] <= alu_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         RegWrite <= 1'b0;
         rd       <= '0;
         w_data   <= '0;
      end else begin
         r_wptr   <= r_wptr + PW'(w_npush);
         r_count  <= r_count + CW'(w_npush) - CW'(w_pop);
         RegWrite <= w_pop;
         if (w_pop) begin
            rd     <= r_q_rd[r_rptr];
            w_data <= r_q_dat[r_rptr];
            r_rptr <= r_rptr + PW'(1);
         end
      end
   end

   // Lowest priority first; each later match overrides, so the youngest source wins.
   // The output stage counts because the RF only captures on the mid-cycle negedge.
   always_comb begin
      w_fwd1 = r_data1;
      w_fwd2 = r_data2;
      if (RegWrite && (rd == rs)) w_fwd1 = w_data;
      if (RegWrite && (rd == rt)) w_fwd2 = w_data;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < r_count) begin
            if (r_q_rd[r_rptr + PW'(i)] == rs) w_fwd1 = r_q_dat[r_rptr + PW'(i)];
            if (r_q_rd[r_rptr + PW'(i)] == rt) w_fwd2 = r_q_dat[r_rptr + PW'(i)];
         end
      end
      if (w_mem_push && (mem_rd == rs)) w_fwd1 = mem_data;
      if (w_mem_push && (mem_rd == rt)) w_fwd2 = mem_data;
      if (w_alu_push && (alu_rd == rs)) w_fwd1 = alu_data;
      if (w_alu_push && (alu_rd == rt)) w_fwd2 = alu_data;
   end

   assign fwd_data1 = w_fwd1;
   assign fwd_data2 = w_fwd2;

`ifdef RF_WBQ_STALL_CNT_EN
   logic        w_stall;
   logic [15:0] r_stall_cnt;

   assign w_stall = (alu_valid & ~alu_ready) | (mem_valid & ~mem_ready);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule
